// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule definitions: FSM states, round count, FK constants and CK generation.
package sm4_pkg;

  localparam int NUM_ROUNDS = 32;

  localparam logic [31:0] FK0 = 32'ha3b1bac6;
  localparam logic [31:0] FK1 = 32'h56aa3350;
  localparam logic [31:0] FK2 = 32'h677d9197;
  localparam logic [31:0] FK3 = 32'hb27022dc;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } sm4_state_e;

  // Byte j (MSB first) of CK(i) is (4i+j)*7 mod 256; the 8-bit product truncates the modulus.
  function automatic logic [31:0] sm4_ck(input logic [4:0] round);
    logic [31:0] ck;
    logic [7:0]  idx;
    ck = 32'h0;
    for (int j = 0; j < 4; j++) begin
      idx = {1'b0, round, 2'(j)};
      ck[31-8*j -: 8] = idx * 8'd7;
    end
    return ck;
  endfunction

endpackage

// File: rtl/sm4_ck_gen.sv
// Combinational CK parameter for the current key-expansion round.
module sm4_ck_gen (
  input  logic [4:0]  round_i,
  output logic [31:0] ck_o
);
  import sm4_pkg::*;

  assign ck_o = sm4_ck(round_i);

endmodule

// File: rtl/sm4_key_sched_ctrl.sv
// SM4 key-schedule controller: steps an external expansion round 32 times and serves the round keys.
// Optional feature macro SM4_KEY_SCRUB_EN: zero the round-key file on clear and on every key accept.
module sm4_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 32,
  parameter int RK_W       = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            key_valid_i,
  output logic            key_ready_o,
  input  logic [127:0]    key_i,
  input  logic            clear_i,
  output logic [4:0]      round_count_o,
  output logic [127:0]    round_data_o,
  output logic [31:0]     ck_o,
  input  logic [127:0]    round_result_i,
  output logic            busy_o,
  output logic            keys_valid_o,
  input  logic            decrypt_i,
  input  logic [4:0]      rk_idx_i,
  output logic [RK_W-1:0] rk_o
);
  import sm4_pkg::*;

  if (NUM_ROUNDS != 32) begin : g_rounds_chk
    $error("sm4_key_sched_ctrl: NUM_ROUNDS must be 32");
  end

`ifdef SM4_KEY_SCRUB_EN
  localparam logic SCRUB_EN = 1'b1;
`else
  localparam logic SCRUB_EN = 1'b0;
`endif

  localparam logic [4:0] LAST_RND = 5'(NUM_ROUNDS - 1);

  sm4_state_e      fsm_q, fsm_d;
  logic [127:0]    state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            kv_q, kv_d;
  logic            key_ready_s;
  logic            rk_we_s;
  logic            rk_clr_s;
  logic [4:0]      rd_idx_s;
  logic [RK_W-1:0] rk_q [NUM_ROUNDS];

  sm4_ck_gen u_ck_gen (
    .round_i (cnt_q),
    .ck_o    (ck_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q   <= ST_IDLE;
      state_q <= 128'h0;
      cnt_q   <= 5'd0;
      kv_q    <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kv_q    <= kv_d;
    end
  end

  // Clear outranks a key accept; the counter wraps to zero on the final round write.
  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    kv_d     = kv_q;
    rk_we_s  = 1'b0;
    rk_clr_s = 1'b0;
    case (fsm_q)
      ST_EXPAND: key_ready_s = 1'b0;
      default:   key_ready_s = 1'b1;
    endcase
    if (clear_i) begin
      fsm_d    = ST_IDLE;
      state_d  = 128'h0;
      cnt_d    = 5'd0;
      kv_d     = 1'b0;
      rk_clr_s = SCRUB_EN;
    end else if (key_valid_i && key_ready_s) begin
      fsm_d    = ST_EXPAND;
      state_d  = key_i;
      cnt_d    = 5'd0;
      kv_d     = 1'b0;
      rk_clr_s = SCRUB_EN;
    end else if (fsm_q == ST_EXPAND) begin
      state_d = round_result_i;
      rk_we_s = 1'b1;
      cnt_d   = cnt_q + 5'd1;
      if (cnt_q == LAST_RND) begin
        fsm_d = ST_DONE;
        kv_d  = 1'b1;
      end else begin
        fsm_d = ST_EXPAND;
      end
    end else begin
      fsm_d = fsm_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ROUNDS; i++) rk_q[i] <= '0;
    end else if (rk_clr_s) begin
      for (int i = 0; i < NUM_ROUNDS; i++) rk_q[i] <= '0;
    end else if (rk_we_s) begin
      rk_q[cnt_q] <= round_result_i[RK_W-1:0];
    end
  end

  assign rd_idx_s      = decrypt_i ? (LAST_RND - rk_idx_i) : rk_idx_i;
  assign rk_o          = rk_q[rd_idx_s];
  assign key_ready_o   = key_ready_s;
  assign busy_o        = (fsm_q == ST_EXPAND);
  assign keys_valid_o  = kv_q;
  assign round_count_o = cnt_q;
  assign round_data_o  = state_q;

endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Bench for sm4_key_sched_ctrl: supplies the SM4 expansion round and checks against a key-schedule model.
module tb_sm4_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid_i, key_ready_o, clear_i, busy_o, keys_valid_o, decrypt_i;
  logic [127:0] key_i, round_data_o, round_result_i;
  logic [4:0]   round_count_o, rk_idx_i;
  logic [31:0]  ck_o, rk_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef logic [31:0] rk_arr_t [32];
  localparam logic [127:0] FK_V  = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
  localparam logic [127:0] KEY_K = 128'h01234567_89abcdef_fedcba98_76543210;

  logic [7:0] sbox [0:255] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  function automatic logic [31:0] ck_model(input int i);
    logic [31:0] c;
    c = 32'h0;
    for (int j = 0; j < 4; j++) c[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
    return c;
  endfunction

  function automatic logic [31:0] tprime(input logic [31:0] x);
    logic [31:0] b;
    b = {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  function automatic rk_arr_t expand(input logic [127:0] key);
    logic [31:0]  k [36];
    rk_arr_t      rk;
    logic [127:0] kx;
    kx = key ^ FK_V;
    for (int i = 0; i < 4; i++) k[i] = kx[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      k[i+4] = k[i] ^ tprime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_model(i));
      rk[i]  = k[i+4];
    end
    return rk;
  endfunction

  // The external expansion round: whitening with FK on round 0, then one key-schedule step.
  function automatic logic [127:0] round_env(input logic [4:0] cnt, input logic [127:0] data);
    logic [127:0] k;
    k = (cnt == 5'd0) ? (data ^ FK_V) : data;
    return {k[95:0], k[127:96] ^ tprime(k[95:64] ^ k[63:32] ^ k[31:0] ^ ck_model(int'(cnt)))};
  endfunction

  assign round_result_i = round_env(round_count_o, round_data_o);

  always #5 clk = ~clk;

  sm4_key_sched_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .key_valid_i    (key_valid_i),
    .key_ready_o    (key_ready_o),
    .key_i          (key_i),
    .clear_i        (clear_i),
    .round_count_o  (round_count_o),
    .round_data_o   (round_data_o),
    .ck_o           (ck_o),
    .round_result_i (round_result_i),
    .busy_o         (busy_o),
    .keys_valid_o   (keys_valid_o),
    .decrypt_i      (decrypt_i),
    .rk_idx_i       (rk_idx_i),
    .rk_o           (rk_o)
  );

  task automatic sweep_rk(input rk_arr_t exp, input string tag);
    logic [31:0] want;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        decrypt_i = d[0];
        rk_idx_i  = 5'(i);
        #1;
        want = (d != 0) ? exp[31-i] : exp[i];
        n_cmp++;
        if (rk_o !== want) begin
          n_err++;
          $display("FAIL %s rk dec=%0d idx=%0d: got %h want %h", tag, d, i, rk_o, want);
        end
      end
    end
    decrypt_i = 1'b0;
    rk_idx_i  = 5'd0;
    @(posedge clk); #1;
  endtask

  task automatic start_key(input logic [127:0] k, input string tag);
    int t = 0;
    while (key_ready_o !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    n_cmp++;
    if (t >= 100) begin
      n_err++;
      $display("FAIL %s ready-timeout: key_ready=%b after %0d cycles, want 1", tag, key_ready_o, t);
    end
    key_i       = k;
    key_valid_i = 1'b1;
    @(posedge clk); #1;
    key_valid_i = 1'b0;
  endtask

  task automatic run_expand(input string tag);
    for (int r = 0; r < 32; r++) begin
      n_cmp++;
      if (busy_o !== 1'b1 || keys_valid_o !== 1'b0 || key_ready_o !== 1'b0 ||
          round_count_o !== 5'(r) || ck_o !== ck_model(r)) begin
        n_err++;
        $display("FAIL %s expand r=%0d: busy=%b kv=%b rdy=%b cnt=%0d ck=%h, want 1 0 0 %0d %h",
                 tag, r, busy_o, keys_valid_o, key_ready_o, round_count_o, ck_o, r, ck_model(r));
      end
      if ((r == 0 && ck_o !== 32'h00070e15) || (r == 1 && ck_o !== 32'h1c232a31) ||
          (r == 31 && ck_o !== 32'h646b7279)) begin
        n_err++;
        $display("FAIL %s ck_const r=%0d: got %h", tag, r, ck_o);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (keys_valid_o !== 1'b1 || busy_o !== 1'b0 || key_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s done: kv=%b busy=%b rdy=%b, want 1 0 1", tag, keys_valid_o, busy_o, key_ready_o);
    end
  endtask

  task automatic test_reset();
    rk_arr_t zero;
    for (int i = 0; i < 32; i++) zero[i] = 32'h0;
    n_cmp++;
    if (key_ready_o !== 1'b1 || busy_o !== 1'b0 || keys_valid_o !== 1'b0 ||
        round_count_o !== 5'd0 || round_data_o !== 128'h0) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b busy=%b kv=%b cnt=%0d data=%h, want 1 0 0 0 0",
               key_ready_o, busy_o, keys_valid_o, round_count_o, round_data_o);
    end
    sweep_rk(zero, "reset_rk");
  endtask

  task automatic test_known_vector();
    logic [31:0] got [5];
    logic [31:0] want [5] = '{32'hf12186f9, 32'h41662b61, 32'h9124a012, 32'h9124a012, 32'hf12186f9};
    logic [4:0]  idx  [5] = '{5'd0, 5'd1, 5'd31, 5'd0, 5'd31};
    start_key(KEY_K, "known");
    run_expand("known");
    for (int i = 0; i < 5; i++) begin
      decrypt_i = (i >= 3);
      rk_idx_i  = idx[i];
      #1;
      got[i] = rk_o;
      n_cmp++;
      if (got[i] !== want[i]) begin
        n_err++;
        $display("FAIL known_rk dec=%b idx=%0d: got %h want %h", decrypt_i, idx[i], got[i], want[i]);
      end
    end
    decrypt_i = 1'b0;
    @(posedge clk); #1;
    sweep_rk(expand(KEY_K), "known_model");
  endtask

  task automatic test_clear();
    logic [127:0] kb, kc;
    rk_arr_t      ea, eb;
    logic [31:0]  exp5, exp20;
    kb = {$urandom, $urandom, $urandom, $urandom};
    kc = {$urandom, $urandom, $urandom, $urandom};
    ea = expand(KEY_K);
    eb = expand(kb);
    start_key(kb, "clear");
    repeat (10) begin @(posedge clk); #1; end
    n_cmp++;
    if (round_count_o !== 5'd10) begin
      n_err++;
      $display("FAIL clear_at10: cnt=%0d want 10", round_count_o);
    end
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || key_ready_o !== 1'b1 || keys_valid_o !== 1'b0 ||
        round_count_o !== 5'd0 || round_data_o !== 128'h0) begin
      n_err++;
      $display("FAIL clear_state: busy=%b rdy=%b kv=%b cnt=%0d data=%h, want 0 1 0 0 0",
               busy_o, key_ready_o, keys_valid_o, round_count_o, round_data_o);
    end
`ifdef SM4_KEY_SCRUB_EN
    exp5  = 32'h0;
    exp20 = 32'h0;
`else
    exp5  = eb[5];
    exp20 = ea[20];
`endif
    rk_idx_i = 5'd5; #1;
    n_cmp++;
    if (rk_o !== exp5) begin
      n_err++;
      $display("FAIL clear_rk5: got %h want %h", rk_o, exp5);
    end
    rk_idx_i = 5'd20; #1;
    n_cmp++;
    if (rk_o !== exp20) begin
      n_err++;
      $display("FAIL clear_rk20: got %h want %h", rk_o, exp20);
    end
    rk_idx_i = 5'd0;
    @(posedge clk); #1;
    clear_i     = 1'b1;
    key_valid_i = 1'b1;
    key_i       = kc;
    @(posedge clk); #1;
    clear_i     = 1'b0;
    key_valid_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (busy_o !== 1'b0 || keys_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL clear_priority: busy=%b kv=%b, want 0 0", busy_o, keys_valid_o);
    end
    start_key(kc, "fresh");
    run_expand("fresh");
    sweep_rk(expand(kc), "fresh_model");
  endtask

  task automatic test_back_to_back();
    logic [127:0] kc, kd;
    kc = {$urandom, $urandom, $urandom, $urandom};
    kd = {$urandom, $urandom, $urandom, $urandom};
    start_key(kc, "b2b");
    for (int r = 0; r < 32; r++) begin
      if (r == 3) begin key_i = kd; key_valid_i = 1'b1; end
      if (r == 20) key_valid_i = 1'b0;
      n_cmp++;
      if (busy_o !== 1'b1 || round_count_o !== 5'(r)) begin
        n_err++;
        $display("FAIL b2b_ignore r=%0d: busy=%b cnt=%0d, want 1 %0d", r, busy_o, round_count_o, r);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (keys_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done: kv=%b want 1", keys_valid_o);
    end
    sweep_rk(expand(kc), "b2b_model");
    start_key(kd, "rekey");
    run_expand("rekey");
    sweep_rk(expand(kd), "rekey_model");
  endtask

  task automatic test_random_keys();
    logic [127:0] k;
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      start_key(k, "rand");
      run_expand("rand");
      sweep_rk(expand(k), "rand_model");
    end
  endtask

  task automatic test_async_reset();
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    start_key(k, "arst");
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (key_ready_o !== 1'b1 || busy_o !== 1'b0 || keys_valid_o !== 1'b0 ||
        round_count_o !== 5'd0 || round_data_o !== 128'h0 || rk_o !== 32'h0) begin
      n_err++;
      $display("FAIL arst_state: rdy=%b busy=%b kv=%b cnt=%0d data=%h rk=%h, want 1 0 0 0 0 0",
               key_ready_o, busy_o, keys_valid_o, round_count_o, round_data_o, rk_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    n_cmp++;
    if (keys_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL arst_after: kv=%b busy=%b, want 0 0", keys_valid_o, busy_o);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    key_valid_i = 1'b0;
    key_i       = 128'h0;
    clear_i     = 1'b0;
    decrypt_i   = 1'b0;
    rk_idx_i    = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_known_vector();
    test_clear();
    test_back_to_back();
    test_random_keys();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
